// File: rtl/ivs_dma_rd_axi_mst_if.sv
// Split-command, split-data and AXI3 AR/R signal bundle for the DMA read AXI master.
// The mst modport is the block's view and the slv modport is the environment's view.
interface ivs_dma_rd_axi_mst_if #(
  parameter int DW  = 64,
  parameter int AW  = 32,
  parameter int IDW = 4
);
  logic          split_req;
  logic [AW-1:0] split_base;
  logic [3:0]    split_len;
  logic          split_ack;
  logic [DW-1:0] split_rdata;
  logic          split_valid;
  logic          split_rlast;
  logic          split_rdy;

  logic           m_arvalid;
  logic           m_arready;
  logic [AW-1:0]  m_araddr;
  logic [3:0]     m_arlen;
  logic [2:0]     m_arsize;
  logic [1:0]     m_arburst;
  logic [IDW-1:0] m_arid;
  logic           m_rvalid;
  logic           m_rready;
  logic [DW-1:0]  m_rdata;
  logic [1:0]     m_rresp;
  logic           m_rlast;

  modport mst (
    input  split_req, split_base, split_len, split_rdy,
    input  m_arready, m_rvalid, m_rdata, m_rresp, m_rlast,
    output split_ack, split_rdata, split_valid, split_rlast,
    output m_arvalid, m_araddr, m_arlen, m_arsize, m_arburst, m_arid, m_rready
  );

  modport slv (
    output split_req, split_base, split_len, split_rdy,
    output m_arready, m_rvalid, m_rdata, m_rresp, m_rlast,
    input  split_ack, split_rdata, split_valid, split_rlast,
    input  m_arvalid, m_araddr, m_arlen, m_arsize, m_arburst, m_arid, m_rready
  );
endinterface

// File: rtl/ivs_dma_rd_axi_mst.sv
// Turns one split command into a single AXI3 INCR read burst and returns the beats
// to the split stage through a small registered FIFO, with sticky error status.
module ivs_dma_rd_axi_mst #(
  parameter int             DW         = 64,
  parameter int             AW         = 32,
  parameter int             IDW        = 4,
  parameter logic [IDW-1:0] ARID_VAL   = '0,
  parameter int             FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sw_rst,
  ivs_dma_rd_axi_mst_if.mst       bus,
  output logic                    busy,
  output logic                    err_resp,
  output logic                    err_last
);
  localparam int             PW   = $clog2(FIFO_DEPTH);
  localparam int             CW   = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, AR_SEND, R_WAIT} state_t;

  state_t        state_q, state_d;
  logic          arvalid_q, arvalid_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [3:0]    len_q, len_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          rready_q, rready_d;
  logic          err_resp_q, err_resp_d;
  logic          err_last_q, err_last_d;
  logic [DW:0]   mem_q [FIFO_DEPTH];
  logic [DW:0]   mem_d [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] occ_q, occ_d;

  logic          split_ack_c;
  logic          beat_acc;
  logic          last_flag;
  logic          push;
  logic          pop;
  logic [PW-1:0] head_ptr;

  always_comb begin
    state_d     = state_q;
    arvalid_d   = arvalid_q;
    addr_d      = addr_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    occ_d       = occ_q;
    mem_d       = mem_q;
    split_ack_c = 1'b0;

    // rready_q is only ever high in R_WAIT, so it alone qualifies a beat
    beat_acc  = rready_q & bus.m_rvalid;
    last_flag = (cnt_q == len_q);
    push      = beat_acc;
    pop       = (occ_q != '0) & bus.split_rdy;

    case (state_q)
      IDLE: begin
        if (bus.split_req) begin
          addr_d    = {bus.split_base[AW-1:3], 3'b000};
          len_d     = bus.split_len;
          arvalid_d = 1'b1;
          state_d   = AR_SEND;
        end
      end
      AR_SEND: begin
        if (bus.m_arready) begin
          split_ack_c = 1'b1;
          arvalid_d   = 1'b0;
          state_d     = R_WAIT;
        end
      end
      R_WAIT: begin
        if (beat_acc) begin
          if (last_flag) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (push) begin
      mem_d[wr_ptr_q] = {bus.m_rdata, last_flag};
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   occ_d = occ_q + CW'(1);
      2'b01:   occ_d = occ_q - CW'(1);
      default: occ_d = occ_q;
    endcase

    // Registered from next occupancy: a freed slot reopens R one cycle after the pop
    rready_d = (state_d == R_WAIT) && (occ_d != FULL);

    err_resp_d = (err_resp_q & ~sw_rst) | (beat_acc & (bus.m_rresp != 2'b00));
    err_last_d = (err_last_q & ~sw_rst) | (beat_acc & (bus.m_rlast != last_flag));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      arvalid_q  <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      rready_q   <= 1'b0;
      err_resp_q <= 1'b0;
      err_last_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      arvalid_q  <= arvalid_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      rready_q   <= rready_d;
      err_resp_q <= err_resp_d;
      err_last_q <= err_last_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      mem_q      <= mem_d;
    end
  end

  // When empty, point at the slot just popped so split_rdata holds its last value
  assign head_ptr = (occ_q == '0) ? (rd_ptr_q - PW'(1)) : rd_ptr_q;

  assign bus.split_ack   = split_ack_c;
  assign bus.split_valid = (occ_q != '0);
  assign bus.split_rdata = mem_q[head_ptr][DW:1];
  assign bus.split_rlast = (occ_q != '0) & mem_q[head_ptr][0];

  assign bus.m_arvalid = arvalid_q;
  assign bus.m_araddr  = addr_q;
  assign bus.m_arlen   = len_q;
  assign bus.m_arsize  = 3'b011;
  assign bus.m_arburst = 2'b01;
  assign bus.m_arid    = ARID_VAL;
  assign bus.m_rready  = rready_q;

  assign busy     = (state_q != IDLE) | (occ_q != '0);
  assign err_resp = err_resp_q;
  assign err_last = err_last_q;
endmodule

// File: tb/tb_ivs_dma_rd_axi_mst.sv
// Directed bench for ivs_dma_rd_axi_mst: inputs change 1 time unit after the rising
// edge, outputs are observed on the falling edge.
module tb_ivs_dma_rd_axi_mst;
  localparam int DW  = 64;
  localparam int AW  = 32;
  localparam int IDW = 4;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic sw_rst = 1'b0;
  logic busy, err_resp, err_last;

  ivs_dma_rd_axi_mst_if #(.DW(DW), .AW(AW), .IDW(IDW)) bus ();

  ivs_dma_rd_axi_mst #(
    .DW(DW), .AW(AW), .IDW(IDW), .ARID_VAL(4'd0), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sw_rst(sw_rst), .bus(bus),
    .busy(busy), .err_resp(err_resp), .err_last(err_last)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [64:0] rx_q [$];
  int acc_beats = 0;
  int acks      = 0;
  int cyc       = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      cyc++;
      if (bus.split_valid && bus.split_rdy) rx_q.push_back({bus.split_rlast, bus.split_rdata});
      if (bus.m_rvalid && bus.m_rready) acc_beats++;
      if (bus.split_ack) acks++;
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic obs();
    @(negedge clk);
  endtask

  task automatic r_beat(input logic [63:0] d, input logic [1:0] resp, input logic last);
    int   t;
    logic acc;
    t   = 0;
    acc = 1'b0;
    bus.m_rvalid = 1'b1;
    bus.m_rdata  = d;
    bus.m_rresp  = resp;
    bus.m_rlast  = last;
    while (!acc && t < 100) begin
      @(negedge clk);
      acc = bus.m_rready;
      @(posedge clk);
      #1;
      t++;
    end
    bus.m_rvalid = 1'b0;
    bus.m_rresp  = 2'b00;
    bus.m_rlast  = 1'b0;
    if (!acc) chk("r_beat_timeout", 64'd0, 64'd1);
  endtask

  task automatic cmd(input logic [31:0] base, input logic [3:0] len, input bit keep);
    int   t;
    logic got;
    t   = 0;
    got = 1'b0;
    bus.split_req  = 1'b1;
    bus.split_base = base;
    bus.split_len  = len;
    while (!got && t < 50) begin
      @(negedge clk);
      got = bus.split_ack;
      @(posedge clk);
      #1;
      t++;
    end
    if (!keep) bus.split_req = 1'b0;
    if (!got) chk("cmd_ack_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_rx(input string tag, input int n);
    int t;
    t = 0;
    while (rx_q.size() < n && t < 200) begin
      step();
      t++;
    end
    chk(tag, rx_q.size(), n);
  endtask

  task automatic pop_rx(input string tag, input logic [63:0] d, input logic last);
    logic [64:0] item;
    item = (rx_q.size() > 0) ? rx_q.pop_front() : 65'h1_DEAD_DEAD_DEAD_DEAD;
    chk({tag, "_d"}, item[63:0], d);
    chk({tag, "_l"}, {63'd0, item[64]}, {63'd0, last});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    bus.split_req  = 1'b0;
    bus.split_base = '0;
    bus.split_len  = '0;
    bus.split_rdy  = 1'b0;
    bus.m_arready  = 1'b0;
    bus.m_rvalid   = 1'b0;
    bus.m_rdata    = '0;
    bus.m_rresp    = 2'b00;
    bus.m_rlast    = 1'b0;

    // Reset state
    step(3);
    obs();
    chk("rst_arvalid", bus.m_arvalid, 0);
    chk("rst_rready", bus.m_rready, 0);
    chk("rst_ack", bus.split_ack, 0);
    chk("rst_valid", bus.split_valid, 0);
    chk("rst_rdata", bus.split_rdata, 0);
    chk("rst_araddr", bus.m_araddr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_errs", {err_resp, err_last}, 0);
    chk("rst_arsize", bus.m_arsize, 3);
    chk("rst_arburst", bus.m_arburst, 1);
    chk("rst_arid", bus.m_arid, 0);
    step();
    rst_n = 1'b1;

    // Single beat, unaligned base
    bus.m_arready  = 1'b1;
    bus.split_rdy  = 1'b1;
    bus.split_req  = 1'b1;
    bus.split_base = 32'h0000_1003;
    bus.split_len  = 4'd0;
    obs();
    chk("t1_ack_idle", bus.split_ack, 0);
    step();
    obs();
    chk("t1_arvalid", bus.m_arvalid, 1);
    chk("t1_ack", bus.split_ack, 1);
    chk("t1_araddr", bus.m_araddr, 32'h1000);
    chk("t1_arlen", bus.m_arlen, 0);
    step();
    bus.split_req = 1'b0;
    obs();
    chk("t1_ack_pulse", bus.split_ack, 0);
    chk("t1_arvalid_low", bus.m_arvalid, 0);
    chk("t1_rready", bus.m_rready, 1);
    step();
    r_beat(64'hA5A5, 2'b00, 1'b1);
    obs();
    chk("t1_valid", bus.split_valid, 1);
    chk("t1_rdata", bus.split_rdata, 64'hA5A5);
    chk("t1_rlast", bus.split_rlast, 1);
    chk("t1_busy", busy, 1);
    chk("t1_rready_off", bus.m_rready, 0);
    step();
    obs();
    chk("t1_valid_off", bus.split_valid, 0);
    chk("t1_busy_off", busy, 0);
    chk("t1_rdata_hold", bus.split_rdata, 64'hA5A5);
    rx_q.delete();

    // 16-beat burst behind a 5-cycle AR stall
    step();
    bus.m_arready  = 1'b0;
    bus.split_req  = 1'b1;
    bus.split_base = 32'h0000_2000;
    bus.split_len  = 4'd15;
    step();
    for (int k = 0; k < 5; k++) begin
      obs();
      chk($sformatf("t2_stall_v%0d", k), bus.m_arvalid, 1);
      chk($sformatf("t2_stall_a%0d", k), bus.m_araddr, 32'h2000);
      chk($sformatf("t2_stall_l%0d", k), bus.m_arlen, 15);
      chk($sformatf("t2_stall_k%0d", k), bus.split_ack, 0);
      step();
    end
    bus.m_arready = 1'b1;
    obs();
    chk("t2_ack", bus.split_ack, 1);
    step();
    bus.split_req = 1'b0;
    obs();
    chk("t2_arvalid_low", bus.m_arvalid, 0);
    step();
    c0 = cyc;
    for (int i = 0; i < 16; i++) r_beat(64'h1000 + 64'(i), 2'b00, i == 15);
    chk("t2_thru", cyc - c0, 16);
    wait_rx("t2_cnt", 16);
    for (int i = 0; i < 16; i++) pop_rx($sformatf("t2_b%0d", i), 64'h1000 + 64'(i), i == 15);

    // Backpressure: split stage stalls 10 cycles during an 8-beat burst
    step();
    bus.split_rdy = 1'b0;
    cmd(32'h0000_3008, 4'd7, 1'b0);
    acc_beats = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) r_beat(64'h3000 + 64'(i), 2'b00, i == 7);
      end
      begin
        step(6);
        obs();
        chk("t3_rready_full", bus.m_rready, 0);
        chk("t3_beats_in", acc_beats, 4);
        step(4);
        bus.split_rdy = 1'b1;
      end
    join
    wait_rx("t3_cnt", 8);
    for (int i = 0; i < 8; i++) pop_rx($sformatf("t3_b%0d", i), 64'h3000 + 64'(i), i == 7);

    // Outstanding limit: request held through a len=3 burst
    step(2);
    acks = 0;
    cmd(32'h0000_4010, 4'd3, 1'b1);
    bus.split_base = 32'h0000_5044;
    bus.split_len  = 4'd1;
    for (int i = 0; i < 4; i++) begin
      r_beat(64'h4000 + 64'(i), 2'b00, i == 3);
      if (i < 3) begin
        obs();
        chk($sformatf("t4_blk_a%0d", i), bus.m_arvalid, 0);
        step();
        obs();
        chk($sformatf("t4_blk_b%0d", i), bus.m_arvalid, 0);
        step();
      end
    end
    obs();
    chk("t4_idle_arvalid", bus.m_arvalid, 0);
    chk("t4_acks1", acks, 1);
    step();
    obs();
    chk("t4_arvalid2", bus.m_arvalid, 1);
    chk("t4_araddr2", bus.m_araddr, 32'h5040);
    chk("t4_ack2", bus.split_ack, 1);
    step();
    bus.split_req = 1'b0;
    obs();
    chk("t4_acks2", acks, 2);
    step();
    r_beat(64'h5000, 2'b00, 1'b0);
    r_beat(64'h5001, 2'b00, 1'b1);
    wait_rx("t4_cnt", 6);
    for (int i = 0; i < 4; i++) pop_rx($sformatf("t4_b%0d", i), 64'h4000 + 64'(i), i == 3);
    pop_rx("t4_b4", 64'h5000, 1'b0);
    pop_rx("t4_b5", 64'h5001, 1'b1);

    // Errors: bad RRESP on beat 2, early RLAST on beat 3 of a 5-beat burst
    step();
    cmd(32'h0000_6000, 4'd4, 1'b0);
    r_beat(64'h6000, 2'b00, 1'b0);
    r_beat(64'h6001, 2'b10, 1'b0);
    obs();
    chk("t5_eresp", err_resp, 1);
    chk("t5_elast0", err_last, 0);
    step();
    r_beat(64'h6002, 2'b00, 1'b1);
    obs();
    chk("t5_elast", err_last, 1);
    step();
    r_beat(64'h6003, 2'b00, 1'b0);
    r_beat(64'h6004, 2'b00, 1'b1);
    wait_rx("t5_cnt", 5);
    for (int i = 0; i < 5; i++) pop_rx($sformatf("t5_b%0d", i), 64'h6000 + 64'(i), i == 4);
    step();
    obs();
    chk("t5_errs_sticky", {err_resp, err_last}, 2'b11);
    chk("t5_busy", busy, 0);
    step();
    cmd(32'h0000_6100, 4'd2, 1'b0);
    sw_rst = 1'b1;
    r_beat(64'h6100, 2'b00, 1'b0);
    sw_rst = 1'b0;
    obs();
    chk("t5_clr", {err_resp, err_last}, 2'b00);
    chk("t5_busy_clr", busy, 1);
    step();
    sw_rst = 1'b1;
    r_beat(64'h6101, 2'b01, 1'b0);
    sw_rst = 1'b0;
    obs();
    chk("t5_set_wins", {err_resp, err_last}, 2'b10);
    step();
    r_beat(64'h6102, 2'b00, 1'b1);
    wait_rx("t5b_cnt", 3);
    for (int i = 0; i < 3; i++) pop_rx($sformatf("t5b_b%0d", i), 64'h6100 + 64'(i), i == 2);
    sw_rst = 1'b1;
    step();
    sw_rst = 1'b0;
    obs();
    chk("t5_clr2", {err_resp, err_last}, 2'b00);

    // Asynchronous reset in the middle of R_WAIT
    step();
    bus.split_rdy = 1'b0;
    cmd(32'h0000_7000, 4'd3, 1'b0);
    r_beat(64'h7000, 2'b00, 1'b0);
    r_beat(64'h7001, 2'b00, 1'b0);
    sw_rst = 1'b0;
    bus.m_rresp = 2'b00;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_valid", bus.split_valid, 0);
    chk("t6_rdata", bus.split_rdata, 0);
    chk("t6_rready", bus.m_rready, 0);
    chk("t6_busy", busy, 0);
    chk("t6_araddr", bus.m_araddr, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.split_rdy = 1'b1;
    rx_q.delete();
    obs();
    chk("t6_idle_valid", bus.split_valid, 0);
    chk("t6_idle_busy", busy, 0);
    step();
    cmd(32'h0000_7100, 4'd0, 1'b0);
    r_beat(64'h7100, 2'b00, 1'b1);
    wait_rx("t6_cnt", 1);
    pop_rx("t6_b0", 64'h7100, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ivs_dma_rd_axi_mst.md
Name: ivs_dma_rd_axi_mst

Overview:
- Downstream neighbour of the DMA read split stage: turns its split command (split_req/split_base/split_len, max 16 beats, never crossing 4 KB) into one AXI3 read burst.
- Returns R-channel beats to the split stage through a small registered FIFO, honouring split_rdy backpressure.
- One burst outstanding at a time; sticky error status for bad RRESP and RLAST/length mismatch.

Parameters:
- DW, 64, data width in bits (equals BDWD).
- AW, 32, address width.
- IDW, 4, AXI ID width.
- ARID_VAL, 0, constant ARID driven on every burst.
- FIFO_DEPTH, 4, R data FIFO entries (power of two, >=2).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- sw_rst  in  1  clears sticky status; does not abort traffic
- split_req  in  1  command request, held until split_ack
- split_base  in  AW  byte start address
- split_len  in  4  beats minus 1
- split_ack  out  1  one-cycle command accept pulse
- split_rdata  out  DW  read data to split stage
- split_valid  out  1  split_rdata valid
- split_rlast  out  1  last beat of current burst
- split_rdy  in  1  split stage accepts beat
- m_arvalid / m_arready  out / in  1  AXI AR handshake
- m_araddr  out  AW  {split_base[AW-1:3],3'b0}
- m_arlen  out  4  split_len
- m_arsize  out  3  constant 3'b011
- m_arburst  out  2  constant 2'b01 (INCR)
- m_arid  out  IDW  ARID_VAL
- m_rvalid / m_rready  in / out  1  AXI R handshake
- m_rdata  in  DW  read data
- m_rresp  in  2  read response
- m_rlast  in  1  AXI last beat
- busy  out  1  state != IDLE or FIFO not empty
- err_resp  out  1  sticky: any beat with m_rresp != 0
- err_last  out  1  sticky: m_rlast mismatches beat count

Behaviour:
- Reset: every output 0 except the constants (m_arsize, m_arburst, m_arid). FSM in IDLE, FIFO empty, beat counter 0.
- FSM states: IDLE, AR_SEND, R_WAIT.
  - IDLE: when split_req=1, latch aligned address and len; m_arvalid=1 next cycle; go to AR_SEND.
  - AR_SEND: m_arvalid and the AR fields hold stable until m_arready. On handshake: split_ack=1 in that same cycle, m_arvalid=0 next cycle, go to R_WAIT.
  - R_WAIT: m_rready = FIFO not full. Each accepted beat (m_rvalid & m_rready) pushes {rdata, last_flag} and increments the beat counter.
  - last_flag = (beat counter == latched len). split_rlast is driven from last_flag, not from m_rlast.
  - After the beat with last_flag=1: return to IDLE and clear the counter.
- Outstanding limit: split_req is not accepted (no ack, no arvalid) while in R_WAIT, even if the FIFO drains. Minimum gap between acks = len+1 beats + 1 cycle.
- err_last: set if m_rlast=1 on a beat where last_flag=0, or m_rlast=0 where last_flag=1. FSM still follows the beat count.
- err_resp: set on any accepted beat with m_rresp != 0; the data is still forwarded.
- Both error flags are sticky; cleared only by sw_rst or rst_n. If sw_rst and an error occur in the same cycle, set wins.
- sw_rst never touches m_arvalid, the FSM, the counter or the FIFO; an in-flight burst completes (AXI valid may not be withdrawn).
- FIFO timing:
  - A beat accepted in cycle t is visible on split_valid in t+1 (registered output, no bypass).
  - A pop happens on split_valid & split_rdy.
  - Push and pop in the same cycle are allowed when not full; occupancy is unchanged.
  - When full, m_rready=0. A pop that frees a slot raises m_rready in the next cycle only (m_rready is registered from occupancy, no combinational path from split_rdy).
  - When empty, split_valid=0 and split_rdata holds its last value.
- Throughput: with split_rdy=1 and m_rvalid=1 continuously, one beat per cycle through a FIFO of depth >=2.
- Width rules: beat counter is 4 bits, compared to the 4-bit len. m_araddr bits [2:0] are always 0.

Test Plan:
- Single beat: split_base=0x1003, split_len=0, m_arready=1 immediately -> m_araddr=0x1000, m_arlen=0, split_ack one pulse; one R beat 0xA5A5 -> split_valid one cycle later with split_rlast=1; busy falls after the pop.
- 16-beat burst with AR stall: m_arready low 5 cycles -> m_arvalid and fields stable, ack in the cycle m_arready=1; 16 back-to-back beats -> 16 in-order split_valid beats, split_rlast only on beat 16.
- Backpressure: split_rdy=0 for 10 cycles during an 8-beat burst -> m_rready falls after 4 beats; no data lost; order preserved when split_rdy returns.
- Outstanding block: split_req held after ack of len=3 -> no second m_arvalid until the 4th R beat is accepted; second ack follows.
- Errors: m_rresp=2'b10 on beat 2 and m_rlast early on beat 3 of len=4 -> err_resp=1, err_last=1, 5 beats still delivered; sw_rst pulse -> both flags 0 next cycle, burst unaffected.
- Async reset mid-R_WAIT -> all outputs 0 immediately, FIFO empty, IDLE on release.
